alu_mc: RTL and testbench

Parametrised, registered ALU with valid/ready handshakes on input and output, status flags, and a multi-cycle shift-add multiplier. Opcodes 0x0–0x7 keep the existing 3-bit ALU encoding, widened to 4 bits. It sits between the operand-fetch stage and the writeback stage. It accepts one operation at a time and holds each result until the consumer takes it.

---
 rtl/alu_mc.sv | 170 +++++++++++++++++
 tb/tb_alu_mc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Registered ALU with valid/ready handshakes, status flags and a multi-cycle
// shift-add multiplier (MULL/MULH). One operation in flight at a time.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic {IDLE, MUL} state_t;

    state_t state, state_nx;

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high. Operands are sampled only on an input transfer; x and flags
    // stay stable while out_valid is high and out_ready is low.
    logic accept, handoff, is_mul_op, mul_done;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign handoff   = out_valid && out_ready;
    assign is_mul_op = (opcode == 4'h8) || (opcode == 4'h9);

    logic [WIDTH-1:0]   mcand, mplier;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0]   cnt;
    logic               mul_hi;

    assign mul_done = (state == MUL) && (cnt == CNT_W'(WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && is_mul_op) state_nx = MUL;
            MUL:     if (mul_done)            state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Single-cycle operations
    logic [WIDTH:0]   sum_ab, dif_ab, inc_a, inc_b;
    logic [WIDTH-1:0] res;
    logic             res_c, res_v;

    assign sum_ab = {1'b0, a} + {1'b0, b};
    assign dif_ab = {1'b0, a} - {1'b0, b};
    assign inc_a  = {1'b0, a} + (WIDTH+1)'(1);
    assign inc_b  = {1'b0, b} + (WIDTH+1)'(1);

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (opcode)
            4'h0: res = a | b;
            4'h1: res = a & b;
            4'h2: res = a ^ b;
            4'h3: res = ~a;
            4'h4: begin
                res   = sum_ab[WIDTH-1:0];
                res_c = sum_ab[WIDTH];
                res_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ab[WIDTH-1] != a[WIDTH-1]);
            end
            4'h5: begin
                res   = dif_ab[WIDTH-1:0];
                res_c = dif_ab[WIDTH];
                res_v = (a[WIDTH-1] != b[WIDTH-1]) && (dif_ab[WIDTH-1] != a[WIDTH-1]);
            end
            4'h6: begin
                res   = inc_a[WIDTH-1:0];
                res_c = inc_a[WIDTH];
                res_v = (a == MAX_POS);
            end
            4'h7: begin
                res   = inc_b[WIDTH-1:0];
                res_c = inc_b[WIDTH];
                res_v = (b == MAX_POS);
            end
            4'hA: begin
                res   = {a[WIDTH-2:0], 1'b0};
                res_c = a[WIDTH-1];
                res_v = a[WIDTH-1] ^ a[WIDTH-2];
            end
            4'hB: begin
                res   = {1'b0, a[WIDTH-1:1]};
                res_c = a[0];
            end
            default: ;
        endcase
    end

    logic [WIDTH-1:0]   mul_x;
    logic               mul_c;
    logic [2*WIDTH-1:0] partial;

    assign mul_x   = mul_hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    assign mul_c   = !mul_hi && (prod[2*WIDTH-1:WIDTH] != '0);
    assign partial = {{WIDTH{1'b0}}, mcand} << cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            x         <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            cnt       <= '0;
            mul_hi    <= 1'b0;
        end else begin
            if (handoff) out_valid <= 1'b0;
            if (accept) begin
                if (is_mul_op) begin
                    mcand  <= a;
                    mplier <= b;
                    prod   <= '0;
                    cnt    <= '0;
                    mul_hi <= opcode[0];
                end else begin
                    x         <= res;
                    flag_z    <= (res == '0);
                    flag_n    <= res[WIDTH-1];
                    flag_c    <= res_c;
                    flag_v    <= res_v;
                    out_valid <= 1'b1;
                end
            end
            // One shift-add step per cycle; the extra cycle after the last
            // step publishes the product.
            if (state == MUL) begin
                if (mul_done) begin
                    x         <= mul_x;
                    flag_z    <= (mul_x == '0);
                    flag_n    <= mul_x[WIDTH-1];
                    flag_c    <= mul_c;
                    flag_v    <= 1'b0;
                    out_valid <= 1'b1;
                end else begin
                    if (mplier[0]) prod <= prod + partial;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed plan cases plus random operations
// checked against an arithmetic reference model.
module tb_alu_mc;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [3:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] x;
    logic         flag_z, flag_n, flag_c, flag_v;

    int vectors = 0;
    int miscompares = 0;
    int rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled

    logic [W+3:0] exp_q[$];

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
    );

    // Clock / consumer behaviour
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'($urandom_range(0, 1));
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
    end

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference model: returns {x, z, n, c, v}
    function automatic logic [W+3:0] model(longint unsigned ua, longint unsigned ub, int op);
        longint unsigned full = longint'(1) << W;
        longint unsigned mask = full - 1;
        longint unsigned half = full >> 1;
        longint lo = -longint'(half);
        longint hi = longint'(half) - 1;
        longint sa = (ua >= half) ? longint'(ua) - longint'(full) : longint'(ua);
        longint sb = (ub >= half) ? longint'(ub) - longint'(full) : longint'(ub);
        longint sr;
        longint unsigned r = 0;
        longint unsigned p = ua * ub;
        logic c = 1'b0, v = 1'b0;
        logic [W-1:0] rx;
        case (op)
            0: r = ua | ub;
            1: r = ua & ub;
            2: r = ua ^ ub;
            3: r = ~ua & mask;
            4: begin
                r = (ua + ub) & mask; c = (ua + ub) > mask;
                sr = sa + sb; v = (sr < lo) || (sr > hi);
            end
            5: begin
                r = (ua - ub) & mask; c = ua < ub;
                sr = sa - sb; v = (sr < lo) || (sr > hi);
            end
            6: begin r = (ua + 1) & mask; c = (ua == mask); v = (ua == half - 1); end
            7: begin r = (ub + 1) & mask; c = (ub == mask); v = (ub == half - 1); end
            8: begin r = p & mask; c = (p >> W) != 0; end
            9: r = p >> W;
            10: begin
                r = (ua << 1) & mask; c = ua >= half;
                sr = sa * 2; v = (sr < lo) || (sr > hi);
            end
            11: begin r = ua >> 1; c = ua[0]; end
            default: r = 0;
        endcase
        rx = r[W-1:0];
        return {rx, (rx == 0), rx[W-1], c, v};
    endfunction

    // Driver: holds the request until accepted, bounded
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [3:0] iop);
        bit acc = 0;
        in_valid = 1'b1; a = ia; b = ib; opcode = iop;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(ia, ib, int'(iop)));
                acc = 1;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    // Monitor: pops on every output transfer and checks stall stability
    logic [W+3:0] held;
    bit held_v = 0;

    always @(negedge clk) begin
        logic [W+3:0] got;
        got = {x, flag_z, flag_n, flag_c, flag_v};
        if (rst_n && out_valid && held_v) check("stall_stable", got, held);
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_output", 1, 0);
            else check("result", got, exp_q.pop_front());
        end
        held_v = rst_n && out_valid && !out_ready;
        held   = got;
    end

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; opcode = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_x_flags", {x, flag_z, flag_n, flag_c, flag_v}, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset while a result is stalled: it is discarded
        rdy_mode = 2;
        @(posedge clk); #1;
        issue(8'h0F, 8'h01, 4'h4);
        @(negedge clk);
        check("midop_valid_before", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midop_rst_valid", out_valid, 0);
        check("midop_rst_x_flags", {x, flag_z, flag_n, flag_c, flag_v}, 0);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        rdy_mode = 1;
        @(negedge clk);
        check("midop_in_ready_after", in_ready, 1);
        @(posedge clk); #1;

        // Directed plan cases
        issue(8'hFF, 8'h01, 4'h4);
        issue(8'h7F, 8'h01, 4'h4);
        issue(8'h03, 8'h05, 4'h5);
        for (int i = 0; i < 4; i++) issue(8'hA5, 8'h3C, 4'(i));
        issue(8'h12, 8'h34, 4'hE);
        issue(8'hC0, 8'h00, 4'hA);
        issue(8'h01, 8'h00, 4'hB);
        issue(8'h7F, 8'h00, 4'h6);
        issue(8'h00, 8'hFF, 4'h7);

        // Multiplier latency: accept, then 9 cycles with in_ready low
        for (int k = 8; k <= 9; k++) begin
            issue(8'hFF, 8'hFF, 4'(k));
            lat = 0;
            @(negedge clk);
            while (!out_valid && lat < 50) begin
                lat++;
                if (in_ready) check("mul_in_ready_low", in_ready, 0);
                @(negedge clk);
            end
            check("mul_latency", lat, W + 1);
            check("mul_x", x, (k == 8) ? 8'h01 : 8'hFE);
            check("mul_c", flag_c, (k == 8) ? 1 : 0);
            @(posedge clk); #1;
        end

        // Backpressure then same-cycle hand-off and accept
        rdy_mode = 2;
        @(posedge clk); #1;
        issue(8'h01, 8'h02, 4'h4);
        repeat (3) begin
            @(negedge clk);
            check("bp_x", x, 8'h03);
            check("bp_in_ready", in_ready, 0);
        end
        fork
            issue(8'h5A, 8'h0F, 4'h2);
            begin repeat (2) @(posedge clk); rdy_mode = 1; end
        join
        check("b2b_out_valid", out_valid, 1);
        check("b2b_x", x, 8'h55);

        // Random traffic with random consumer stalls
        rdy_mode = 0;
        for (int i = 0; i < 300; i++)
            issue(W'($urandom), W'($urandom), 4'($urandom_range(0, 15)));

        rdy_mode = 1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
